// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared 8-LED bank: sources request, the winner holds
// the bank for a prescaler-timed slot and is rotated out only when someone else waits.
module led_bank_arbiter #(
    parameter int          NUM_SRC      = 4,
    parameter int          SYS_CLK_FREQ = 204_000_000,
    parameter int          TICK_FREQ    = 4,
    parameter int          SLOT_TICKS   = 8,
    parameter logic [7:0]  IDLE_PATTERN = 8'h81
) (
    input  logic                   sysclk,
    input  logic                   resetn,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [8*NUM_SRC-1:0]   led_data,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic [7:0]             led_out,
    output logic                   tick
);

    localparam int DIV = SYS_CLK_FREQ / TICK_FREQ;
    localparam int PW  = $clog2(DIV);
    localparam int SW  = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int RW  = $clog2(NUM_SRC);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_TICKS - 1);
    localparam logic [RW-1:0] IDX_LAST   = RW'(NUM_SRC - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [SW-1:0]        slot_cnt_q, slot_cnt_d;
    logic [RW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [7:0]           led_out_q, led_out_d;

    logic [NUM_SRC-1:0]   cand;
    logic                 pick_valid;
    logic [RW-1:0]        pick_idx;
    logic [NUM_SRC-1:0]   pick_oh;
    logic [RW-1:0]        pick_next_ptr;
    logic                 holder_req;
    logic [7:0]           led_masked [NUM_SRC];

    assign tick    = (presc_q == PRESC_LAST);
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign led_out = led_out_q;

    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end

    // In IDLE grant_q is zero, so one masked candidate set serves both states.
    assign cand       = req & ~grant_q;
    assign holder_req = |(req & grant_q);

    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        // Scan from the far end so the lowest offset from rr_ptr wins.
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr_q) + off) % NUM_SRC;
            if (cand[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = RW'(idx);
            end
        end
    end

    assign pick_oh       = {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx;
    assign pick_next_ptr = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        slot_cnt_d = slot_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_oh;
                    slot_cnt_d = '0;
                    rr_ptr_d   = pick_next_ptr;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!holder_req) begin
                    slot_cnt_d = '0;
                    if (pick_valid) begin
                        grant_d  = pick_oh;
                        rr_ptr_d = pick_next_ptr;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    if (slot_cnt_q != SLOT_LAST) begin
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end else if (pick_valid) begin
                        grant_d    = pick_oh;
                        slot_cnt_d = '0;
                        rr_ptr_d   = pick_next_ptr;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_led_mask
            assign led_masked[gi] = grant_q[gi] ? led_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        led_out_d = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            led_out_d = led_out_d | led_masked[i];
        end
        if (grant_q == '0) begin
            led_out_d = IDLE_PATTERN;
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            slot_cnt_q <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            led_out_q  <= IDLE_PATTERN;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            slot_cnt_q <= slot_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            led_out_q  <= led_out_d;
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with a 16-cycle tick and 2-tick slots.
module tb_led_bank_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [31:0] led_data;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  led_out;
    logic        tick;

    int checks   = 0;
    int failures = 0;

    led_bank_arbiter #(
        .NUM_SRC      (4),
        .SYS_CLK_FREQ (16),
        .TICK_FREQ    (1),
        .SLOT_TICKS   (2),
        .IDLE_PATTERN (8'h81)
    ) dut (
        .sysclk   (clk),
        .resetn   (resetn),
        .req      (req),
        .led_data (led_data),
        .grant    (grant),
        .busy     (busy),
        .led_out  (led_out),
        .tick     (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Waits until the n-th tick is visible, then crosses the edge that acts on it.
    task automatic wait_ticks(input int n);
        int  cnt;
        bit  found;
        cnt   = 0;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            if (tick === 1'b1) begin
                cnt++;
                if (cnt == n) found = 1;
            end
            step();
        end
        if (!found) chk("tick_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        req      = 4'b0000;
        led_data = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
        resetn   = 1'b1;
        #1;

        // 1: reset state and prescaler period
        resetn = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_led", 32'(led_out), 32'h81);
        chk("rst_tick", 32'(tick), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("tick_k%0d", k), 32'(tick), (k == 15 || k == 31) ? 32'd1 : 32'd0);
        end
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_led", 32'(led_out), 32'h81);

        // 2: single requester, led_out lags grant by one cycle
        req = 4'b0100;
        step();
        chk("t2_grant", 32'(grant), 32'h4);
        chk("t2_busy", 32'(busy), 32'h1);
        chk("t2_led_lag", 32'(led_out), 32'h81);
        step();
        chk("t2_led", 32'(led_out), 32'hA5);
        repeat (40) step();
        chk("t2_hold", 32'(grant), 32'h4);
        req = 4'b0000;
        step();
        chk("t2_release", 32'(grant), 32'h0);
        chk("t2_busy0", 32'(busy), 32'h0);
        step();
        chk("t2_led_idle", 32'(led_out), 32'h81);

        // 3: two contenders rotate every two ticks
        do_reset();
        req = 4'b1001;
        step();
        chk("t3_first", 32'(grant), 32'h1);
        wait_ticks(1);
        chk("t3_mid", 32'(grant), 32'h1);
        wait_ticks(1);
        chk("t3_rot1", 32'(grant), 32'h8);
        step();
        chk("t3_led3", 32'(led_out), 32'hC3);
        wait_ticks(2);
        chk("t3_rot2", 32'(grant), 32'h1);
        step();
        chk("t3_led0", 32'(led_out), 32'h3C);

        // 4: holder drops mid-slot, waiter takes over without a tick
        req = 4'b0000;
        do_reset();
        req = 4'b0010;
        step();
        chk("t4_grant1", 32'(grant), 32'h2);
        req = 4'b1010;
        wait_ticks(1);
        chk("t4_still1", 32'(grant), 32'h2);
        chk("t4_slot1", 32'(dut.slot_cnt_q), 32'h1);
        step();
        step();
        req = 4'b1000;
        step();
        chk("t4_grant3", 32'(grant), 32'h8);
        chk("t4_slot0", 32'(dut.slot_cnt_q), 32'h0);

        // 5: sole requester keeps the bank, slot counter saturates
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        step();
        chk("t5_grant", 32'(grant), 32'h1);
        wait_ticks(10);
        chk("t5_hold", 32'(grant), 32'h1);
        chk("t5_sat", 32'(dut.slot_cnt_q), 32'h1);

        // 6: asynchronous reset mid-slot, arbitration restarts from source 0
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        step();
        chk("t6_grant2", 32'(grant), 32'h4);
        repeat (3) step();
        chk("t6_led2", 32'(led_out), 32'hA5);
        resetn = 1'b0;
        #2;
        chk("t6_async_grant", 32'(grant), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_led", 32'(led_out), 32'h81);
        req = 4'b0101;
        #1;
        resetn = 1'b1;
        step();
        chk("t6_restart", 32'(grant), 32'h1);
        step();
        chk("t6_led0", 32'(led_out), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
